// File: rtl/raster_scheduler.sv
// rtl/raster_scheduler.sv - frame-level fetch/cull/start sequencer for rast_triangle
//
// Purpose: walks the triangle memory for one frame, culls degenerate and
// off-screen triangles, runs the rast_start/rast_done handshake with the
// rasterizer and gates the per-pixel handshake towards the frame writer.
// Optional macro RAST_BACKFACE_CULL_EN: also cull clockwise (A<0) triangles.
//
// Ports:
//   CLK, RESET_N                 clock, synchronous active-low reset
//   frame_start, tri_count       frame command (rising edge starts a frame)
//   mem_rd, mem_addr             one-cycle triangle read request, triangle index
//   mem_valid, mem_v1..3         read response; vertex = {x, y, z, uv}, 32 bits each,
//                                x in [127:96], y in [95:64], signed with 8 fraction bits
//   rast_v1..3, rast_start       latched vertices and start level to the rasterizer
//   rast_done, rast_draw_ready   rasterizer done level and pixel valid
//   rast_cont                    pixel accept to the rasterizer
//   pix_valid, pix_ready         pixel handshake towards the writer
//   frame_busy, frame_done       frame status, end-of-frame pulse
//   tri_drawn, tri_culled        saturating per-frame triangle counters

module raster_scheduler #(
    parameter int ADDR_W   = 10,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              frame_start,
    input  logic [ADDR_W:0]   tri_count,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [127:0]      mem_v1,
    input  logic [127:0]      mem_v2,
    input  logic [127:0]      mem_v3,
    output logic [127:0]      rast_v1,
    output logic [127:0]      rast_v2,
    output logic [127:0]      rast_v3,
    output logic              rast_start,
    input  logic              rast_done,
    input  logic              rast_draw_ready,
    output logic              rast_cont,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              frame_busy,
    output logic              frame_done,
    output logic [ADDR_W:0]   tri_drawn,
    output logic [ADDR_W:0]   tri_culled
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_CULL,
        S_START,
        S_RELEASE,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic signed [63:0] X_LIM = 64'(SCREEN_W) <<< 8;
    localparam logic signed [63:0] Y_LIM = 64'(SCREEN_H) <<< 8;

    state_t          state;
    logic            frame_start_q;
    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] index_q;

    logic signed [63:0] x1, y1, x2, y2, x3, y3, area;
    logic               degenerate, off_screen, backface, cull;

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Cull test works on the latched vertices, which are stable during CULL.
    always_comb begin
        x1 = {{32{rast_v1[127]}}, rast_v1[127:96]};
        y1 = {{32{rast_v1[95]}},  rast_v1[95:64]};
        x2 = {{32{rast_v2[127]}}, rast_v2[127:96]};
        y2 = {{32{rast_v2[95]}},  rast_v2[95:64]};
        x3 = {{32{rast_v3[127]}}, rast_v3[127:96]};
        y3 = {{32{rast_v3[95]}},  rast_v3[95:64]};
        area = (x2 - x1) * (y3 - y1) - (x3 - x1) * (y2 - y1);
        degenerate = (area == 64'sd0);
        off_screen = (x1 < 64'sd0 && x2 < 64'sd0 && x3 < 64'sd0)
                  || (x1 >= X_LIM && x2 >= X_LIM && x3 >= X_LIM)
                  || (y1 < 64'sd0 && y2 < 64'sd0 && y3 < 64'sd0)
                  || (y1 >= Y_LIM && y2 >= Y_LIM && y3 >= Y_LIM);
`ifdef RAST_BACKFACE_CULL_EN
        backface = (area < 64'sd0);
`else
        backface = 1'b0;
`endif
        cull = degenerate | off_screen | backface;
    end

    // rast_start is high exactly while in START, so gating on it would be
    // equivalent; the state compare keeps the pixel path independent of it.
    assign pix_valid = rast_draw_ready & (state == S_START);
    assign rast_cont = pix_ready & (state == S_START);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state         <= S_IDLE;
            frame_start_q <= 1'b0;
            count_q       <= '0;
            index_q       <= '0;
            mem_rd        <= 1'b0;
            mem_addr      <= '0;
            rast_v1       <= '0;
            rast_v2       <= '0;
            rast_v3       <= '0;
            rast_start    <= 1'b0;
            frame_busy    <= 1'b0;
            frame_done    <= 1'b0;
            tri_drawn     <= '0;
            tri_culled    <= '0;
        end else begin
            frame_start_q <= frame_start;
            mem_rd        <= 1'b0;
            frame_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start && !frame_start_q) begin
                        count_q    <= tri_count;
                        index_q    <= '0;
                        tri_drawn  <= '0;
                        tri_culled <= '0;
                        if (tri_count == '0) begin
                            state      <= S_FINISH;
                            frame_done <= 1'b1;
                            frame_busy <= 1'b0;
                        end else begin
                            state      <= S_FETCH;
                            frame_busy <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    mem_rd   <= 1'b1;
                    mem_addr <= index_q[ADDR_W-1:0];
                    state    <= S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    if (mem_valid) begin
                        rast_v1 <= mem_v1;
                        rast_v2 <= mem_v2;
                        rast_v3 <= mem_v3;
                        state   <= S_CULL;
                    end
                end
                S_CULL: begin
                    if (cull) begin
                        tri_culled <= sat_inc(tri_culled);
                        state      <= S_NEXT;
                    end else begin
                        rast_start <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (rast_done) begin
                        rast_start <= 1'b0;
                        tri_drawn  <= sat_inc(tri_drawn);
                        state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!rast_done) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    index_q <= index_q + 1'b1;
                    if ((index_q + 1'b1) == count_q) begin
                        state      <= S_FINISH;
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/raster_scheduler.md
# raster_scheduler

Frame-level controller that sequences `rast_triangle`. It fetches triangles from the triangle memory one at a time, culls degenerate and off-screen triangles, and drives the `start`/`done` handshake of the rasterizer. It also gates the per-pixel `cont` handshake between the rasterizer and the downstream z-buffer/framebuffer writer. It sits between the frame command interface and `rast_triangle`.

## Interface
- ADDR_W, 10, triangle memory address width; max triangles per frame = 2^ADDR_W
- SCREEN_W, 640, screen width in pixels (compared as SCREEN_W<<8)
- SCREEN_H, 480, screen height in pixels (compared as SCREEN_H<<8)

Ports. Clock is `CLK`. Reset is `RESET_N`: one clock, reset synchronous and active-low.
- CLK  in  1  clock
- RESET_N  in  1  synchronous active-low reset
- frame_start  in  1  level; a rising edge in IDLE begins a frame
- tri_count  in  ADDR_W+1  triangles in frame; sampled at frame start
- mem_rd  out  1  one-cycle triangle read request
- mem_addr  out  ADDR_W  triangle index
- mem_valid  in  1  read data valid; arbitrary latency ≥1 cycle
- mem_v1/mem_v2/mem_v3  in  4x32 each  vertex {x, y, z, packed uv}; x/y/z signed, 8 fractional bits
- rast_v1/rast_v2/rast_v3  out  4x32 each  latched vertices to rasterizer
- rast_start  out  1  rasterizer start; held until done
- rast_done  in  1  rasterizer done level
- rast_draw_ready  in  1  rasterizer pixel valid
- rast_cont  out  1  pixel accept to rasterizer
- pix_valid  out  1  pixel valid to writer
- pix_ready  in  1  writer ready
- frame_busy  out  1  high from frame accept to frame_done
- frame_done  out  1  one-cycle pulse at end of frame
- tri_drawn  out  ADDR_W+1  triangles rasterized this frame
- tri_culled  out  ADDR_W+1  triangles culled this frame

## Operation
- States: IDLE, FETCH, WAIT_MEM, CULL, START, RELEASE, NEXT, FINISH.
- IDLE: on a `frame_start` rising edge (edge-detected internally), latch `tri_count`, clear index, `tri_drawn` and `tri_culled`, set `frame_busy`.
  - If `tri_count`==0, go to FINISH.
  - Otherwise go to FETCH.
- FETCH: `mem_rd`=1 for exactly one cycle with `mem_addr`=index, then WAIT_MEM.
- WAIT_MEM: on `mem_valid`, latch `mem_v*` into `rast_v*` and go to CULL. `rast_v*` hold their value until the next latch.
- CULL: one cycle. The triangle is culled if any of these holds:
  - Degenerate: signed area A=(x2-x1)*(y3-y1)-(x3-x1)*(y2-y1) equals 0. A is computed in 64-bit signed arithmetic.
  - Off-screen: all three x <0, or all three x ≥SCREEN_W<<8, or all three y <0, or all three y ≥SCREEN_H<<8.
  - If culled: increment `tri_culled` and go to NEXT.
  - Otherwise: go to START.
- START: `rast_start`=1. Remain in START until `rast_done`=1 is sampled, then increment `tri_drawn` and go to RELEASE.
- RELEASE: `rast_start`=0. Remain until `rast_done`=0, then go to NEXT.
- NEXT: increment index.
  - If index+1 == `tri_count`, go to FINISH.
  - Otherwise go to FETCH.
- FINISH: `frame_done`=1 for one cycle, `frame_busy`=0, then IDLE.
- Pixel gating (combinational):
  - `pix_valid` = `rast_draw_ready` & (state==START).
  - `rast_cont` = `pix_ready` & (state==START).
  - Outside START, `rast_cont`=0.
- `frame_start` edges while `frame_busy` are ignored. `tri_count` changes mid-frame are ignored.
- Counters saturate at 2^(ADDR_W+1)-1. They hold their values after FINISH until the next frame start.

## Timing
- Reset: state IDLE; all outputs 0, including `rast_v*`, the counters and `mem_addr`. The edge detector history is cleared to 0.
- Reset mid-frame: abort immediately with `rast_start`=0 on the next cycle and no `frame_done`. The rasterizer shares the reset.
- Cycle after the `frame_start` edge: FETCH. `mem_rd` is high on the second cycle after the edge (one cycle for the edge register).
- WAIT_MEM→CULL→START: `rast_start` rises 2 cycles after the `mem_valid` cycle.
- Culled triangle: FETCH of the next triangle occurs 2 cycles after the CULL cycle.
- `rast_done` and `rast_draw_ready` are sampled registered-free. `rast_cont` has zero-cycle latency from `pix_ready`.
- A triangle the rasterizer finishes with zero pixels is still counted in `tri_drawn`.

## Configuration
- `RAST_BACKFACE_CULL_EN` defined: CULL also rejects A<0 (clockwise in screen space) and counts it in `tri_culled`.
- Undefined: only degenerate and off-screen triangles are culled. Both windings are rasterized.

## Test plan
- Reset, then `tri_count`=3, 3 visible triangles, mem latency 2, `pix_ready`=1 → 3 `rast_start` pulses, each held until `rast_done`; one `frame_done`; `tri_drawn`=3, `tri_culled`=0.
- Triangle (0,0),(256,256),(512,512) (collinear) and triangle with all x=-256 in a 2-triangle frame → no `rast_start`; `tri_culled`=2; `frame_done` 3 cycles after the last `mem_valid` at most.
- `pix_ready` toggling 1,0,0,1 during START with `rast_draw_ready`=1 → `rast_cont` follows `pix_ready` exactly; `pix_valid`=1 throughout.
- `tri_count`=0 → `frame_done` pulse and no `mem_rd`. Second `frame_start` edge while busy → ignored, one `frame_done` only.
- `RESET_N`=0 while in START → next cycle `rast_start`=0, `frame_busy`=0, counters 0, no `frame_done`.
- Clockwise triangle (0,0),(0,2560),(2560,0): with `RAST_BACKFACE_CULL_EN` → culled, `tri_culled`=1; without it → rasterized, `tri_drawn`=1.
